// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select codes and the default register-index width.
package hazard_ctrl_pkg;

    localparam int unsigned REG_BITS = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one E-stage source operand; M result beats W result,
// and register 0 is never forwarded.
module fwd_unit #(
    parameter int unsigned REG_BITS = hazard_ctrl_pkg::REG_BITS
) (
    input  logic [REG_BITS-1:0] src_i,
    input  logic                regWrite_M_i,
    input  logic [REG_BITS-1:0] writeReg_M_i,
    input  logic                regWrite_W_i,
    input  logic [REG_BITS-1:0] writeReg_W_i,
    output logic [1:0]          fwd_o
);
    import hazard_ctrl_pkg::*;

    always_comb begin
        fwd_o = FWD_RF;
        if (regWrite_M_i && (writeReg_M_i != '0) && (writeReg_M_i == src_i)) begin
            fwd_o = FWD_M;
        end else if (regWrite_W_i && (writeReg_W_i != '0) && (writeReg_W_i == src_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush, E-stage forwarding,
// load-use / memory-wait / redirect sequencing and stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_BITS    = hazard_ctrl_pkg::REG_BITS,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  rs_D,
    input  logic [REG_BITS-1:0]  rt_D,
    input  logic [REG_BITS-1:0]  rs_E,
    input  logic [REG_BITS-1:0]  rt_E,
    input  logic [REG_BITS-1:0]  writeReg_E,
    input  logic [REG_BITS-1:0]  writeReg_M,
    input  logic [REG_BITS-1:0]  writeReg_W,
    input  logic                 regWrite_E,
    input  logic                 regWrite_M,
    input  logic                 regWrite_W,
    input  logic                 memToReg_E,
    input  logic                 memReq_M,
    input  logic                 memAck_M,
    input  logic                 redirect_E,
    output logic [1:0]           forwardA_E,
    output logic [1:0]           forwardB_E,
    output logic                 stall_F,
    output logic                 stall_D,
    output logic                 stall_E,
    output logic                 stall_M,
    output logic                 stall_W,
    output logic                 flush_D,
    output logic                 flush_E,
    output logic                 flush_M,
    output logic                 flush_W,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] flushCount
);
    import hazard_ctrl_pkg::*;

    hz_state_e            state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic                 memTimeout_q, memTimeout_d;
    logic [CNT_WIDTH-1:0] stallCount_q, flushCount_q;
    logic [1:0]           fwdA, fwdB;
    logic                 lu;

    fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
        .src_i        (rs_E),
        .regWrite_M_i (regWrite_M),
        .writeReg_M_i (writeReg_M),
        .regWrite_W_i (regWrite_W),
        .writeReg_W_i (writeReg_W),
        .fwd_o        (fwdA)
    );

    fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
        .src_i        (rt_E),
        .regWrite_M_i (regWrite_M),
        .writeReg_M_i (writeReg_M),
        .regWrite_W_i (regWrite_W),
        .writeReg_W_i (writeReg_W),
        .fwd_o        (fwdB)
    );

    assign forwardA_E = reset ? fwdA : FWD_RF;
    assign forwardB_E = reset ? fwdB : FWD_RF;

    assign lu = memToReg_E && regWrite_E && (writeReg_E != '0) &&
                ((writeReg_E == rs_D) || (writeReg_E == rt_D));

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        memTimeout_d = memTimeout_q;
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        stall_W = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        flush_W = 1'b0;

        case (state_q)
            // RUN and the ack cycle of MEM_WAIT share one decision tree, so a
            // redirect or load-use held off by the wait is acted on at the ack.
            ST_RUN, ST_MEM_WAIT: begin
                if (memReq_M && !memAck_M) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    stall_E = 1'b1;
                    stall_M = 1'b1;
                    flush_W = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        timer_d = 8'd1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                        if (timer_d == MEM_TIMEOUT) begin
                            state_d      = ST_HALT;
                            memTimeout_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                    if (redirect_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (lu) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                stall_W = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        // Reset is asynchronous, so the Mealy outputs are masked directly.
        if (!reset) begin
            stall_F = 1'b0;
            stall_D = 1'b0;
            stall_E = 1'b0;
            stall_M = 1'b0;
            stall_W = 1'b0;
            flush_D = 1'b0;
            flush_E = 1'b0;
            flush_M = 1'b0;
            flush_W = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            timer_q      <= '0;
            memTimeout_q <= 1'b0;
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            memTimeout_q <= memTimeout_d;
            if (stall_F) begin
                stallCount_q <= stallCount_q + CNT_WIDTH'(1);
            end
            if (flush_E) begin
                flushCount_q <= flushCount_q + CNT_WIDTH'(1);
            end
        end
    end

    assign memTimeout = memTimeout_q;
    assign stallCount = stallCount_q;
    assign flushCount = flushCount_q;

endmodule
